// File: rtl/traffic_pkg.sv
// Shared types and default phase durations for the junction sequencer.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    PED_WALK  = 3'd6,
    PED_FLASH = 3'd7
  } phase_t;

  localparam int unsigned T_GREEN_DEF  = 4;
  localparam int unsigned T_YELLOW_DEF = 3;
  localparam int unsigned T_ALLRED_DEF = 1;
  localparam int unsigned T_WALK_DEF   = 5;
  localparam int unsigned T_FLASH_DEF  = 3;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;

  localparam lamp_t LAMP_RED    = lamp_t'(3'b100);
  localparam lamp_t LAMP_YELLOW = lamp_t'(3'b010);
  localparam lamp_t LAMP_GREEN  = lamp_t'(3'b001);

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter in tick units; done flags the tick that ends a phase.
module phase_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         done
);

  logic [W-1:0] cnt;

  // Load has priority; the owner asserts it on reset and on every phase entry.
  always_ff @(posedge clk) begin
    if (load) begin
      cnt <= load_val;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = tick && (cnt == '0);

endmodule

// File: rtl/intersection_controller.sv
// Two-way junction sequencer with an on-request pedestrian phase.
module intersection_controller
  import traffic_pkg::*;
#(
  parameter int unsigned T_GREEN  = T_GREEN_DEF,
  parameter int unsigned T_YELLOW = T_YELLOW_DEF,
  parameter int unsigned T_ALLRED = T_ALLRED_DEF,
  parameter int unsigned T_WALK   = T_WALK_DEF,
  parameter int unsigned T_FLASH  = T_FLASH_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic ped_req,
  output logic ns_red,
  output logic ns_yellow,
  output logic ns_green,
  output logic ew_red,
  output logic ew_yellow,
  output logic ew_green,
  output logic walk,
  output logic flash,
  output logic dont,
  output logic ped_wait
);

  localparam int unsigned T_MAX =
    max_u(max_u(max_u(T_GREEN, T_YELLOW), max_u(T_ALLRED, T_WALK)), T_FLASH);
  localparam int unsigned W = $clog2(T_MAX) + 1;

  generate
    if ((T_GREEN < 1) || (T_YELLOW < 1) || (T_ALLRED < 1) || (T_WALK < 1) || (T_FLASH < 1)) begin : g_bad_timing
      $error("intersection_controller: every T_* duration must be at least 1");
    end
  endgenerate

  function automatic logic [W-1:0] dur_m1(input phase_t p);
    case (p)
      NS_GREEN, EW_GREEN:   return W'(T_GREEN - 1);
      NS_YELLOW, EW_YELLOW: return W'(T_YELLOW - 1);
      PED_WALK:             return W'(T_WALK - 1);
      PED_FLASH:            return W'(T_FLASH - 1);
      default:              return W'(T_ALLRED - 1);
    endcase
  endfunction

  phase_t       state;
  phase_t       state_next;
  logic         done;
  logic         load;
  logic [W-1:0] load_val;
  logic         ped_wait_next;
  lamp_t        ns_next;
  lamp_t        ew_next;
  logic         walk_next;
  logic         flash_next;
  logic         dont_next;

  phase_timer #(.W(W)) u_timer (
    .clk      (clk),
    .load     (load),
    .load_val (load_val),
    .tick     (tick),
    .done     (done)
  );

  // Next phase, timer reload and request latch.
  always_comb begin
    state_next = state;
    case (state)
      NS_GREEN:  if (done) state_next = NS_YELLOW;
      NS_YELLOW: if (done) state_next = ALLRED_A;
      ALLRED_A:  if (done) state_next = EW_GREEN;
      EW_GREEN:  if (done) state_next = EW_YELLOW;
      EW_YELLOW: if (done) state_next = ALLRED_B;
      ALLRED_B:  if (done) state_next = ped_wait ? PED_WALK : NS_GREEN;
      PED_WALK:  if (done) state_next = PED_FLASH;
      PED_FLASH: if (done) state_next = NS_GREEN;
      default:   state_next = ALLRED_B;
    endcase

    load     = reset || (state_next != state);
    load_val = reset ? dur_m1(ALLRED_B) : dur_m1(state_next);

    ped_wait_next = ped_wait;
    if ((state_next == PED_WALK) && (state != PED_WALK)) begin
      ped_wait_next = 1'b0;
    end else if (ped_req && (state != PED_WALK)) begin
      ped_wait_next = 1'b1;
    end
  end

  // Lamp decode of the phase being entered, so registered lamps track state.
  always_comb begin
    ns_next    = LAMP_RED;
    ew_next    = LAMP_RED;
    walk_next  = 1'b0;
    flash_next = 1'b0;
    dont_next  = 1'b1;
    case (state_next)
      NS_GREEN:  ns_next = LAMP_GREEN;
      NS_YELLOW: ns_next = LAMP_YELLOW;
      EW_GREEN:  ew_next = LAMP_GREEN;
      EW_YELLOW: ew_next = LAMP_YELLOW;
      PED_WALK: begin
        walk_next = 1'b1;
        dont_next = 1'b0;
      end
      PED_FLASH: begin
        flash_next = 1'b1;
        dont_next  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                          <= ALLRED_B;
      ped_wait                       <= 1'b0;
      {ns_red, ns_yellow, ns_green}  <= LAMP_RED;
      {ew_red, ew_yellow, ew_green}  <= LAMP_RED;
      walk                           <= 1'b0;
      flash                          <= 1'b0;
      dont                           <= 1'b1;
    end else begin
      state                          <= state_next;
      ped_wait                       <= ped_wait_next;
      {ns_red, ns_yellow, ns_green}  <= ns_next;
      {ew_red, ew_yellow, ew_green}  <= ew_next;
      walk                           <= walk_next;
      flash                          <= flash_next;
      dont                           <= dont_next;
    end
  end

endmodule

// File: tb/tb_intersection_controller.sv
// Directed bench for intersection_controller with per-cycle lamp invariants.
module tb_intersection_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0;
  logic ped_req = 1'b0;
  logic ns_red, ns_yellow, ns_green;
  logic ew_red, ew_yellow, ew_green;
  logic walk, flash, dont, ped_wait;

  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;

  // {ns r,y,g, ew r,y,g, walk,flash,dont}
  localparam logic [8:0] NSG = 9'b001_100_001;
  localparam logic [8:0] NSY = 9'b010_100_001;
  localparam logic [8:0] AR  = 9'b100_100_001;
  localparam logic [8:0] EWG = 9'b100_001_001;
  localparam logic [8:0] EWY = 9'b100_010_001;
  localparam logic [8:0] WLK = 9'b100_100_100;
  localparam logic [8:0] FLS = 9'b100_100_010;

  logic [9:0] obs;
  assign obs = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, flash, dont, ped_wait};

  intersection_controller dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .ped_req   (ped_req),
    .ns_red    (ns_red),
    .ns_yellow (ns_yellow),
    .ns_green  (ns_green),
    .ew_red    (ew_red),
    .ew_yellow (ew_yellow),
    .ew_green  (ew_green),
    .walk      (walk),
    .flash     (flash),
    .dont      (dont),
    .ped_wait  (ped_wait)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [8:0] lamps, input logic pw);
    check(tag, 32'(obs), 32'({lamps, pw}));
  endtask

  // Expected lamps after tick t of the plain vehicle cycle (tick 1 enters NS_GREEN).
  function automatic logic [8:0] exp_cycle(input int t);
    int k;
    k = (t - 1) % 16;
    if (k <= 3)       return NSG;
    else if (k <= 6)  return NSY;
    else if (k == 7)  return AR;
    else if (k <= 11) return EWG;
    else if (k <= 14) return EWY;
    else              return AR;
  endfunction

  task automatic cyc(input logic t, input logic p);
    @(negedge clk);
    tick = t;
    ped_req = p;
    @(posedge clk);
    #1;
  endtask

  task automatic period(input logic p);
    cyc(1'b0, p);
    cyc(1'b0, p);
    cyc(1'b0, p);
    cyc(1'b1, p);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    tick = 1'b0;
    ped_req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Lamp invariants sampled away from the active edge.
  always @(negedge clk) begin
    if (armed && !reset) begin
      check("inv_ns_onehot", 32'($countones({ns_red, ns_yellow, ns_green}) == 1), 32'd1);
      check("inv_ew_onehot", 32'($countones({ew_red, ew_yellow, ew_green}) == 1), 32'd1);
      check("inv_conflict", 32'(ns_red || ew_red), 32'd1);
      check("inv_ped_onehot", 32'($countones({walk, flash, dont}) == 1), 32'd1);
      check("inv_walk_red", 32'(!walk || (ns_red && ew_red)), 32'd1);
    end
  end

  initial begin
    // Plain vehicle cycle after reset
    do_reset();
    armed = 1'b1;
    chk("reset_state", AR, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("reset_hold_red", AR, 1'b0);
    cyc(1'b1, 1'b0);
    chk("tick1_ns_green", NSG, 1'b0);
    for (int t = 2; t <= 17; t++) begin
      period(1'b0);
      chk($sformatf("cycle_t%0d", t), exp_cycle(t), 1'b0);
    end

    // Pedestrian request during EW_GREEN
    for (int t = 18; t <= 25; t++) period(1'b0);
    chk("t25_ew_green", EWG, 1'b0);
    cyc(1'b0, 1'b1);
    chk("ped_set", EWG, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    for (int t = 27; t <= 32; t++) begin
      period(1'b0);
      chk($sformatf("ped_pending_t%0d", t), exp_cycle(t), 1'b1);
    end
    // Request held through the walk phase is ignored
    period(1'b1);
    chk("walk_entry_clear", WLK, 1'b0);
    for (int t = 34; t <= 37; t++) begin
      period(1'b1);
      chk($sformatf("walk_hold_t%0d", t), WLK, 1'b0);
    end
    period(1'b1);
    chk("flash_entry", FLS, 1'b0);
    cyc(1'b0, 1'b1);
    chk("flash_req_latched", FLS, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    period(1'b0);
    chk("flash_t40", FLS, 1'b1);
    for (int t = 41; t <= 56; t++) begin
      period(1'b0);
      chk($sformatf("reserve_t%0d", t), exp_cycle(t - 40), 1'b1);
    end
    period(1'b0);
    chk("walk_again", WLK, 1'b0);
    for (int t = 58; t <= 61; t++) period(1'b0);
    chk("walk_t61", WLK, 1'b0);
    for (int t = 62; t <= 64; t++) begin
      period(1'b0);
      chk($sformatf("flash_t%0d", t), FLS, 1'b0);
    end
    for (int t = 65; t <= 70; t++) begin
      period(1'b0);
      chk($sformatf("after_ped_t%0d", t), exp_cycle(t - 64), 1'b0);
    end

    // Reset mid NS_YELLOW (counter at 1)
    do_reset();
    chk("reset_mid_yellow", AR, 1'b0);
    period(1'b0);
    chk("reset_then_ns_green", NSG, 1'b0);

    // Freeze with no ticks in EW_GREEN
    for (int t = 2; t <= 9; t++) period(1'b0);
    chk("freeze_entry", EWG, 1'b0);
    for (int i = 0; i < 100; i++) begin
      cyc(1'b0, 1'b0);
      chk("freeze_outputs", EWG, 1'b0);
    end
    check("freeze_cnt", 32'(dut.u_timer.cnt), 32'd3);
    for (int t = 10; t <= 12; t++) period(1'b0);
    chk("freeze_resume_t12", EWG, 1'b0);
    period(1'b0);
    chk("freeze_resume_t13", EWY, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intersection_controller.md
Name: intersection_controller

Overview:
- Sequences a two-way signalised junction: north-south and east-west vehicle lamps, plus a pedestrian phase served on request.
- Sits above the per-light tick counters and lamp drivers. It owns the single phase timer and the phase order, and drives the lamp enables directly.
- Time is counted in `tick` strobes from the existing clock-divider, not in raw clocks.

Parameters:
- T_GREEN, 4, green duration in ticks (both directions)
- T_YELLOW, 3, yellow duration in ticks
- T_ALLRED, 1, all-red clearance in ticks
- T_WALK, 5, pedestrian walk duration in ticks
- T_FLASH, 3, pedestrian flashing-don't-walk duration in ticks
- Constraint: every T_* must be ≥1. The elaboration check fails otherwise.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock, all state in the clk domain
- tick  in  1  one-cycle timing strobe (e.g. 1 Hz), synchronous to clk
- ped_req  in  1  pedestrian button, level or pulse; any high cycle registers a request
- ns_red / ns_yellow / ns_green  out  1 each  north-south lamps
- ew_red / ew_yellow / ew_green  out  1 each  east-west lamps
- walk  out  1  pedestrian walk lamp
- flash  out  1  flashing don't-walk phase indicator (lamp driver blinks it)
- dont  out  1  steady don't-walk
- ped_wait  out  1  request pending, not yet served

Behaviour:
- States and their next state:
  - NS_GREEN → NS_YELLOW
  - NS_YELLOW → ALLRED_A
  - ALLRED_A → EW_GREEN
  - EW_GREEN → EW_YELLOW
  - EW_YELLOW → ALLRED_B
  - ALLRED_B → PED_WALK if ped_wait, else NS_GREEN
  - PED_WALK → PED_FLASH
  - PED_FLASH → NS_GREEN
- Phase timer:
  - W = clog2(max T_*)+1 bits.
  - On entry to a state, cnt loads T_state−1.
  - On a tick: if cnt==0 the state advances this cycle; otherwise cnt decrements.
  - With no tick, cnt holds. Each state therefore lasts exactly T_state tick periods.
- Outputs are Moore, registered, and decoded from state only.
  - Exactly one lamp per direction is lit in every state.
  - Any direction not in green or yellow shows red.
  - All vehicle lamps are red in ALLRED_A, ALLRED_B, PED_WALK and PED_FLASH.
  - walk=1 only in PED_WALK.
  - flash=1 only in PED_FLASH.
  - dont=1 in all other states. walk, flash and dont are mutually exclusive and exactly one is high.
- ped_wait:
  - Set on any cycle with ped_req=1, except while in PED_WALK, where the request is already being served and is ignored.
  - Cleared on the cycle PED_WALK is entered. If ped_req is high in that same cycle, clear wins.
  - A request during PED_FLASH is latched and served at the next ALLRED_B.
- Reset:
  - state=ALLRED_B, cnt=T_ALLRED−1, ped_wait=0.
  - Reset-value outputs: ns_red=ew_red=1, dont=1, all other outputs 0.
  - Reset mid-phase aborts immediately to this state on the next edge. reset has priority over tick and ped_req.
- tick coinciding with state entry is impossible because entry only occurs on a tick. tick held high for multiple cycles counts once per cycle, which is the caller's responsibility.
- Illegal or unreachable state encodings recover to ALLRED_B on the next clock.

Decomposition:
- Shared package `traffic_pkg`:
  - state enum `phase_t` (8 states)
  - default duration constants
  - a lamp-bundle struct {red, yellow, green}
- Sub-module `phase_timer`: W-bit loadable down-counter with ports load, load_val, tick, and a `done` output (cnt==0 & tick). The controller instantiates one.
- The remaining FSM and output decode stay in this module.

Test Plan:
- Reset, no ped_req, tick every 4 clks → sequence NS_G 4 ticks, NS_Y 3, AR 1, EW_G 4, EW_Y 3, AR 1, repeats.
  - Period is 16 ticks = 64 clks.
  - ns_red=ew_red=1 for the first 4 clks after reset.
- ped_req pulse 1 clk during EW_GREEN → ped_wait=1 next clk.
  - After ALLRED_B: walk=1 for 5 ticks, then flash=1 for 3 ticks, then NS_GREEN.
  - ped_wait=0 from PED_WALK entry.
- ped_req held high through PED_WALK → ped_wait stays 0. ped_req during PED_FLASH → ped_wait=1 and PED_WALK again after the next EW cycle.
- Assert reset for 1 clk mid NS_YELLOW (cnt=1) → next clk all vehicle red, dont=1. NS_GREEN follows after 1 tick.
- tick held 0 for 100 clks in EW_GREEN → all outputs and cnt are frozen, and there is no transition.
- Every cycle, assertion checks:
  - at most one lamp lit per direction
  - never both directions non-red
  - walk/flash/dont are one-hot
  - walk=1 implies all vehicle lamps red
